// File: rtl/multi_cycle_controller_if.sv
// Control bundle between the multi-cycle controller and its datapath:
// instruction fields and ALU flag in, mux selects, ALU op and write enables out.
interface multi_cycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       zero;

  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       pc_write;
  logic       old_pc_write;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_function;
  logic [1:0] result_src;
  logic       halted;

  // Datapath side: supplies IR fields and flags, consumes controls.
  modport master (
    output opcode, f3, f7, zero,
    input  adr_src, mem_write, ir_write, reg_write, pc_write, old_pc_write,
    input  imm_src, alu_src_a, alu_src_b, alu_function, result_src, halted
  );

  // Controller side.
  modport slave (
    input  opcode, f3, f7, zero,
    output adr_src, mem_write, ir_write, reg_write, pc_write, old_pc_write,
    output imm_src, alu_src_a, alu_src_b, alu_function, result_src, halted
  );
endinterface

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32-subset control FSM; outputs decode combinationally from state and IR fields.
// Optional ILLEGAL_TRAP_EN: illegal opcodes park the FSM in ILLEGAL with halted=1 until reset.
module multi_cycle_controller #(
  parameter int unsigned STATE_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  multi_cycle_controller_if.slave ctl_if
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] SRC_A_PC  = 2'd0;
  localparam logic [1:0] SRC_A_OLD = 2'd1;
  localparam logic [1:0] SRC_A_REG = 2'd2;
  localparam logic [1:0] SRC_B_REG = 2'd0;
  localparam logic [1:0] SRC_B_IMM = 2'd1;
  localparam logic [1:0] SRC_B_4   = 2'd2;

  localparam logic [1:0] RES_ALU_OUT = 2'd0;
  localparam logic [1:0] RES_MDR     = 2'd1;
  localparam logic [1:0] RES_ALU     = 2'd2;
  localparam logic [1:0] RES_IMM     = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    FETCH,
    DECODE,
    MEM_ADR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    EXEC_R,
    EXEC_I,
    ALU_WB,
    BRANCH,
    JALR_ADR,
    JUMP,
    LUI,
    ILLEGAL
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_pc_write;
  logic       w_old_pc_write;
  logic [2:0] w_imm_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_alu_function;
  logic [1:0] w_result_src;
  logic       w_unused_f7;

  // Shared R/I-type funct3 decode; sub_en selects SUB for funct3=000.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3_i, input logic sub_en);
    logic [2:0] fn;
    case (f3_i)
      3'b000:  fn = sub_en ? ALU_SUB : ALU_ADD;
      3'b111:  fn = ALU_AND;
      3'b110:  fn = ALU_OR;
      3'b100:  fn = ALU_XOR;
      3'b010:  fn = ALU_SLT;
      default: fn = ALU_ADD;
    endcase
    return fn;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_adr_src      = 1'b0;
    w_mem_write    = 1'b0;
    w_ir_write     = 1'b0;
    w_reg_write    = 1'b0;
    w_pc_write     = 1'b0;
    w_old_pc_write = 1'b0;
    w_imm_src      = IMM_I;
    w_alu_src_a    = SRC_A_PC;
    w_alu_src_b    = SRC_B_REG;
    w_alu_function = ALU_ADD;
    w_result_src   = RES_ALU_OUT;

    case (r_state)
      FETCH: begin
        w_ir_write     = 1'b1;
        w_old_pc_write = 1'b1;
        w_alu_src_a    = SRC_A_PC;
        w_alu_src_b    = SRC_B_4;
        w_result_src   = RES_ALU;
        w_pc_write     = 1'b1;
        w_next_state   = DECODE;
      end

      // Speculatively form the jump/branch target into alu_out.
      DECODE: begin
        w_alu_src_a = SRC_A_OLD;
        w_alu_src_b = SRC_B_IMM;
        w_imm_src   = (ctl_if.opcode == OP_JAL) ? IMM_J : IMM_B;
        case (ctl_if.opcode)
          OP_LOAD, OP_STORE: w_next_state = MEM_ADR;
          OP_R:              w_next_state = EXEC_R;
          OP_I:              w_next_state = EXEC_I;
          OP_BR:             w_next_state = BRANCH;
          OP_JAL:            w_next_state = JUMP;
          OP_JALR:           w_next_state = JALR_ADR;
          OP_LUI:            w_next_state = LUI;
          default:           w_next_state = ILLEGAL;
        endcase
      end

      MEM_ADR: begin
        w_alu_src_a = SRC_A_REG;
        w_alu_src_b = SRC_B_IMM;
        if (ctl_if.opcode == OP_STORE) begin
          w_imm_src    = IMM_S;
          w_next_state = MEM_WRITE;
        end else begin
          w_imm_src    = IMM_I;
          w_next_state = MEM_READ;
        end
      end

      MEM_READ: begin
        w_adr_src    = 1'b1;
        w_result_src = RES_ALU_OUT;
        w_next_state = MEM_WB;
      end

      MEM_WB: begin
        w_result_src = RES_MDR;
        w_reg_write  = 1'b1;
        w_next_state = FETCH;
      end

      MEM_WRITE: begin
        w_adr_src    = 1'b1;
        w_result_src = RES_ALU_OUT;
        w_mem_write  = 1'b1;
        w_next_state = FETCH;
      end

      EXEC_R: begin
        w_alu_src_a    = SRC_A_REG;
        w_alu_src_b    = SRC_B_REG;
        w_alu_function = alu_decode(ctl_if.f3, ctl_if.f7[5]);
        w_next_state   = ALU_WB;
      end

      EXEC_I: begin
        w_alu_src_a    = SRC_A_REG;
        w_alu_src_b    = SRC_B_IMM;
        w_imm_src      = IMM_I;
        w_alu_function = alu_decode(ctl_if.f3, 1'b0);
        w_next_state   = ALU_WB;
      end

      ALU_WB: begin
        w_result_src = RES_ALU_OUT;
        w_reg_write  = 1'b1;
        w_next_state = FETCH;
      end

      // Target sits in alu_out from DECODE; ALU compares rs1/rs2 this cycle.
      BRANCH: begin
        w_alu_src_a  = SRC_A_REG;
        w_alu_src_b  = SRC_B_REG;
        w_result_src = RES_ALU_OUT;
        case (ctl_if.f3)
          3'b000: begin
            w_alu_function = ALU_SUB;
            w_pc_write     = ctl_if.zero;
          end
          3'b001: begin
            w_alu_function = ALU_SUB;
            w_pc_write     = ~ctl_if.zero;
          end
          3'b100: begin
            w_alu_function = ALU_SLT;
            w_pc_write     = ~ctl_if.zero;
          end
          3'b101: begin
            w_alu_function = ALU_SLT;
            w_pc_write     = ctl_if.zero;
          end
          default: w_pc_write = 1'b0;
        endcase
        w_next_state = FETCH;
      end

      JALR_ADR: begin
        w_alu_src_a  = SRC_A_REG;
        w_alu_src_b  = SRC_B_IMM;
        w_imm_src    = IMM_I;
        w_next_state = JUMP;
      end

      // PC takes the target from alu_out while the ALU forms old_pc+4 for rd.
      JUMP: begin
        w_result_src = RES_ALU_OUT;
        w_pc_write   = 1'b1;
        w_alu_src_a  = SRC_A_OLD;
        w_alu_src_b  = SRC_B_4;
        w_next_state = ALU_WB;
      end

      LUI: begin
        w_imm_src    = IMM_U;
        w_result_src = RES_IMM;
        w_reg_write  = 1'b1;
        w_next_state = FETCH;
      end

      ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        w_next_state = ILLEGAL;
`else
        w_next_state = FETCH;
`endif
      end

      default: w_next_state = FETCH;
    endcase
  end

  // Write enables are suppressed while reset is held so no instruction can commit.
  assign ctl_if.adr_src      = w_adr_src;
  assign ctl_if.mem_write    = w_mem_write    & ~reset;
  assign ctl_if.ir_write     = w_ir_write     & ~reset;
  assign ctl_if.reg_write    = w_reg_write    & ~reset;
  assign ctl_if.pc_write     = w_pc_write     & ~reset;
  assign ctl_if.old_pc_write = w_old_pc_write & ~reset;
  assign ctl_if.imm_src      = w_imm_src;
  assign ctl_if.alu_src_a    = w_alu_src_a;
  assign ctl_if.alu_src_b    = w_alu_src_b;
  assign ctl_if.alu_function = w_alu_function;
  assign ctl_if.result_src   = w_result_src;

`ifdef ILLEGAL_TRAP_EN
  assign ctl_if.halted = (r_state == ILLEGAL) & ~reset;
`else
  assign ctl_if.halted = 1'b0;
`endif

  assign w_unused_f7 = &{1'b0, ctl_if.f7[6], ctl_if.f7[4:0]};

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 The block SHALL have parameter STATE_W, default 4: width of the internal state register; it SHALL be at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have inputs opcode (7 bits), f3 (3 bits) and f7 (7 bits), all instruction fields taken from the IR.
REQ-005 The block SHALL have input zero, 1 bit: the ALU zero flag.
REQ-006 The block SHALL have outputs adr_src (1 bit) and mem_write, ir_write, reg_write, pc_write, old_pc_write (1 bit each).
REQ-007 The block SHALL have outputs imm_src (3 bits), alu_src_a (2 bits), alu_src_b (2 bits), alu_function (3 bits) and result_src (2 bits).
REQ-008 The block SHALL have output halted, 1 bit: sticky illegal-instruction indicator.

Function
REQ-009 Encodings SHALL be: adr_src 0=PC, 1=result; alu_src_a 0=PC, 1=old_pc, 2=A; alu_src_b 0=B, 1=imm, 2=const 4; result_src 0=alu_out reg, 1=MDR, 2=ALU output direct, 3=imm.
REQ-010 Further encodings SHALL be: alu_function 0=add, 1=sub, 2=and, 3=or, 4=slt, 5=xor; imm_src 0=I, 1=S, 2=B, 3=J, 4=U.
REQ-011 Outputs SHALL be combinational from state, plus opcode/f3/f7/zero where stated below; every output not listed for a state SHALL be 0.
REQ-012 FETCH SHALL assert adr_src=0, ir_write, old_pc_write, a=PC, b=4, add, result_src=2 and pc_write, then go to DECODE.
REQ-013 DECODE SHALL drive a=old_pc, b=imm, add, with imm_src=J for opcode 1101111 and B otherwise, so that alu_out holds the jump or branch target.
REQ-014 From DECODE the next state SHALL be: 0000011/0100011 -> MEM_ADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JUMP; 1100111 -> JALR_ADR; 0110111 -> LUI; any other opcode -> ILLEGAL.
REQ-015 MEM_ADR SHALL drive a=A, b=imm, add, with imm_src=I for loads and S for stores, then go to MEM_READ for loads or MEM_WRITE for stores.
REQ-016 MEM_READ SHALL drive adr_src=1, result_src=0 and go to MEM_WB; MEM_WB SHALL drive result_src=1 and reg_write and go to FETCH.
REQ-017 MEM_WRITE SHALL drive adr_src=1, result_src=0 and mem_write, then go to FETCH.
REQ-018 EXEC_R SHALL drive a=A, b=B and decode f3 as: 000 -> sub if f7[5]=1 else add; 111 -> and; 110 -> or; 100 -> xor; 010 -> slt; other f3 -> add. It SHALL then go to ALU_WB.
REQ-019 EXEC_I SHALL drive a=A, b=imm, imm_src=I and decode f3 as in REQ-018 except that f7 is ignored (000 is always add), then go to ALU_WB.
REQ-020 ALU_WB SHALL drive result_src=0 and reg_write, then go to FETCH.
REQ-021 BRANCH SHALL drive a=A, b=B and result_src=0, with f3 000/001 -> sub and f3 100/101 -> slt.
REQ-022 In BRANCH, pc_write SHALL equal: zero for f3=000; !zero for 001; !zero for 100; zero for 101; 0 for other f3. BRANCH SHALL then go to FETCH.
REQ-023 JALR_ADR SHALL drive a=A, b=imm, imm_src=I, add, then go to JUMP.
REQ-024 JUMP SHALL drive result_src=0, pc_write, a=old_pc, b=4, add, then go to ALU_WB, so that rd receives old_pc+4.
REQ-025 LUI SHALL drive imm_src=U, result_src=3 and reg_write, then go to FETCH.
REQ-026 Cycle counts per instruction SHALL be: lw 5, sw 4, R 4, I 4, branch 3, jal 4, jalr 5, lui 3.
REQ-027 Write enables SHALL never be asserted in two consecutive cycles for the same instruction except as listed above.

Reset
REQ-028 While reset is high, all write enables SHALL be forced to 0, the state register SHALL load FETCH, and halted SHALL clear to 0.
REQ-029 A reset asserted mid-instruction SHALL abandon that instruction with no further writes; the first cycle after reset deasserts SHALL be FETCH.

Configuration
REQ-030 With ILLEGAL_TRAP_EN defined, ILLEGAL SHALL hold all outputs at 0, set halted=1, and stay in ILLEGAL until reset.
REQ-031 Without ILLEGAL_TRAP_EN, ILLEGAL SHALL be a single no-op cycle returning to FETCH, and halted SHALL be tied to 0.

Verification
REQ-032 The bench SHALL apply reset for 2 cycles and then release it -> all enables 0 during reset; the next cycle is FETCH with ir_write=pc_write=old_pc_write=1.
REQ-033 The bench SHALL drive opcode=0110011, f3=000, f7=0100000 -> states FETCH, DECODE, EXEC_R (alu_function=1), ALU_WB (reg_write=1), then FETCH: 4 cycles.
REQ-034 The bench SHALL drive opcode=1100011, f3=001 with zero=0 and then with zero=1 -> BRANCH pc_write=1 and then 0; a 3-cycle instruction in both cases.
REQ-035 The bench SHALL drive opcode=0000011 -> mem_write never asserted; MEM_READ has adr_src=1; MEM_WB has result_src=1 and reg_write=1: 5 cycles.
REQ-036 The bench SHALL drive opcode=1100111 -> JALR_ADR, then JUMP (pc_write=1, result_src=0), then ALU_WB: 5 cycles.
REQ-037 The bench SHALL drive opcode=1111111 -> with ILLEGAL_TRAP_EN, halted=1 and held until reset; without it, FETCH follows in the next cycle.
